// File: rtl/cfs_tx_fifo.sv
// cfs_tx_fifo: first-word-fall-through FIFO buffering aligned {size, offset, data} words.
// Define CFS_TX_FIFO_LVL_EN to add the fifo_lvl occupancy output.
module cfs_tx_fifo #(
  parameter int ALGN_DATA_WIDTH = 32,
  parameter int FIFO_DEPTH      = 8,
  localparam int ALGN_OFFSET_WIDTH = (ALGN_DATA_WIDTH <= 8) ? 1 : $clog2(ALGN_DATA_WIDTH/8),
  localparam int ALGN_SIZE_WIDTH   = $clog2(ALGN_DATA_WIDTH/8) + 1,
  localparam int FIFO_DATA_WIDTH   = ALGN_DATA_WIDTH + ALGN_OFFSET_WIDTH + ALGN_SIZE_WIDTH,
  localparam int PTR_WIDTH         = $clog2(FIFO_DEPTH)
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clr,
  input  logic                       push_valid,
  input  logic [FIFO_DATA_WIDTH-1:0] push_data,
  output logic                       push_ready,
  output logic                       pop_valid,
  output logic [FIFO_DATA_WIDTH-1:0] pop_data,
  input  logic                       pop_ready,
  output logic                       full,
  output logic                       empty
`ifdef CFS_TX_FIFO_LVL_EN
  ,
  output logic [PTR_WIDTH:0]         fifo_lvl
`endif
);
  logic [FIFO_DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_WIDTH:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic push_fire, pop_fire;
  always_comb begin
    empty      = wr_ptr_q == rd_ptr_q;
    full       = (wr_ptr_q[PTR_WIDTH-1:0] == rd_ptr_q[PTR_WIDTH-1:0]) &&
                 (wr_ptr_q[PTR_WIDTH] != rd_ptr_q[PTR_WIDTH]);
    push_ready = !full;
    pop_valid  = !empty;
    push_fire  = push_valid && !full;
    pop_fire   = pop_ready && !empty;
    wr_ptr_d   = clr ? '0 : wr_ptr_q + (PTR_WIDTH+1)'(push_fire);
    rd_ptr_d   = clr ? '0 : rd_ptr_q + (PTR_WIDTH+1)'(pop_fire);
    pop_data   = empty ? '0 : mem[rd_ptr_q[PTR_WIDTH-1:0]];
  end
`ifdef CFS_TX_FIFO_LVL_EN
  assign fifo_lvl = wr_ptr_q - rd_ptr_q;
`endif
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end
  // storage is deliberately unreset; a flushed push never lands
  always_ff @(posedge clk) begin
    if (push_fire && !clr) mem[wr_ptr_q[PTR_WIDTH-1:0]] <= push_data;
  end
endmodule
